crc_frame_scheduler: RTL and testbench
======================================

CRC_FRAME_SCHEDULER -- requirements
Module: crc_frame_scheduler

Interface
REQ-001 SHALL have parameter MSG_W, default 10, message width in bits.
REQ-002 SHALL have parameter CRC_W, default 9, remainder width (generator degree).
REQ-003 SHALL have parameter P, default 3, bits per engine beat (parallelism).
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-006 SHALL have ports req0/req1, input, 1 each, level request from requester 0/1.
REQ-007 SHALL have ports msg0/msg1, input, MSG_W each, message of requester 0/1, stable while its req is high.
REQ-008 SHALL have ports gnt0/gnt1, output, 1 each, one-cycle pulse: message captured.
REQ-009 SHALL have port crc_clr, output, 1, clears the external 3-parallel CRC engine register to zero.
REQ-010 SHALL have port crc_en, output, 1, engine consumes crc_din this cycle.
REQ-011 SHALL have port crc_din, output, P, beat to the engine; bit [P-1] is the oldest bit.
REQ-012 SHALL have port crc_rem, input, CRC_W, engine remainder; valid the cycle after its last enabled beat.
REQ-013 SHALL have ports res_valid (output, 1), res_ready (input, 1), res_data (output, CRC_W) and res_id (output, 1), the result handshake.

Function
REQ-014 SHALL implement states IDLE, LOAD, SHIFT, CAPT and DONE.
REQ-015 IDLE: with any req high, SHALL grant one requester, pulse its gnt, capture its msg and go to LOAD; otherwise SHALL stay in IDLE.
REQ-016 Padded frame SHALL be {PAD zeros, msg, CRC_W zeros}, where NB = ceil((MSG_W+CRC_W)/P) and PAD = NB*P-MSG_W-CRC_W (defaults: NB=7, PAD=2).
REQ-017 LOAD SHALL last 1 cycle with crc_clr=1 and crc_en=0.
REQ-018 SHIFT SHALL last exactly NB cycles with crc_en=1; beat k (0..NB-1) SHALL be padded[NB*P-1-k*P -: P], MSB first.
REQ-019 CAPT SHALL last 1 cycle and SHALL register crc_rem into res_data.
REQ-020 DONE SHALL hold res_valid=1 with res_data and res_id stable until res_ready=1, then go to IDLE on the next cycle.
REQ-021 Latency: a grant in cycle N SHALL give LOAD in N+1, SHIFT in N+2..N+NB+1, CAPT in N+NB+2 and res_valid in N+NB+3 (N+10 at defaults).
REQ-022 res_ready high while res_valid is low SHALL be ignored; a new request SHALL be granted no earlier than the IDLE cycle after DONE.
REQ-023 A req dropped after its grant SHALL NOT affect the operation in flight; the captured msg SHALL be used.
REQ-024 crc_en, crc_clr and both gnt outputs SHALL be 0 in every state not named above for them.

Reset
REQ-025 While reset=0, SHALL asynchronously force state IDLE, all outputs 0, captured msg 0 and the round-robin pointer to requester 0.
REQ-026 Reset during SHIFT or DONE SHALL abort the operation; no res_valid SHALL follow for that operation.

Configuration
REQ-027 With CRC_SCHED_RR_EN defined, simultaneous requests SHALL be granted round-robin: the pointer favours the requester not granted last; the pointer updates only on a grant.
REQ-028 Without CRC_SCHED_RR_EN, simultaneous requests SHALL be granted fixed priority: requester 0 always wins.

Verification
REQ-029 req0=1, msg0=10'b1100000011, cycle N -> gnt0 in N; crc_din 001,100,000,011,000,000,000 in N+2..N+8; res_valid in N+10, res_id=0, res_data = crc_rem sampled in N+9.
REQ-030 req1=1, msg1=10'b1010110100, res_ready held 0 for 5 cycles -> res_valid and res_data stable for all 5 cycles; IDLE one cycle after res_ready=1.
REQ-031 req0=req1=1 held for 3 operations -> RR_EN: grants 0,1,0; without RR_EN: grants 0,0,0.
REQ-032 reset=0 asserted in the 4th SHIFT cycle -> crc_en=0 and IDLE immediately, no res_valid; after release, a fresh req0 completes normally.
REQ-033 req0 dropped the cycle after gnt0 while msg0 changes -> result is computed from the captured msg; crc_din sequence is unchanged.

Source files
------------

// File: rtl/crc_frame_scheduler.sv
// Two-requester scheduler feeding {pad, msg, zeros} to an external P-bit CRC engine; result in NB+3 cycles after grant.
// Result held on res_valid until res_ready; define CRC_SCHED_RR_EN for round-robin arbitration (default: requester 0 wins).
module crc_frame_scheduler #(
   parameter int MSG_W = 10,
   parameter int CRC_W = 9,
   parameter int P     = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req0,
   input  logic             req1,
   input  logic [MSG_W-1:0] msg0,
   input  logic [MSG_W-1:0] msg1,
   output logic             gnt0,
   output logic             gnt1,
   output logic             crc_clr,
   output logic             crc_en,
   output logic [P-1:0]     crc_din,
   input  logic [CRC_W-1:0] crc_rem,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [CRC_W-1:0] res_data,
   output logic             res_id
);
   localparam int NB = (MSG_W + CRC_W + P - 1) / P;
   localparam int FW = NB * P;
   localparam int CW = $clog2(NB + 1);

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SHIFT, S_CAPT, S_DONE} state_t;

   state_t           r_state;
   logic [FW-1:0]    r_sh;
   logic [CW-1:0]    r_cnt;
   logic             r_clr;
   logic             r_en;
   logic [P-1:0]     r_din;
   logic             r_vld;
   logic [CRC_W-1:0] r_res;
   logic             r_id;

   logic             w_any;
   logic             w_sel;
   logic [MSG_W-1:0] w_msg;
   logic [FW-1:0]    w_frame;

   assign w_any = req0 | req1;

`ifdef CRC_SCHED_RR_EN
   logic r_ptr;
   assign w_sel = (req0 && req1) ? r_ptr : req1;
`else
   assign w_sel = ~req0;
`endif

   assign w_msg   = w_sel ? msg1 : msg0;
   assign w_frame = {{(FW-MSG_W){1'b0}}, w_msg} << CRC_W;

   // Grant is decided in the IDLE cycle itself so the capture happens on that edge.
   assign gnt0 = reset & (r_state == S_IDLE) & w_any & ~w_sel;
   assign gnt1 = reset & (r_state == S_IDLE) & w_any &  w_sel;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
         r_sh    <= '0;
         r_cnt   <= '0;
         r_clr   <= 1'b0;
         r_en    <= 1'b0;
         r_din   <= '0;
         r_vld   <= 1'b0;
         r_res   <= '0;
         r_id    <= 1'b0;
`ifdef CRC_SCHED_RR_EN
         r_ptr   <= 1'b0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_any) begin
                  r_state <= S_LOAD;
                  r_sh    <= w_frame;
                  r_id    <= w_sel;
                  r_clr   <= 1'b1;
`ifdef CRC_SCHED_RR_EN
                  r_ptr   <= ~w_sel;
`endif
               end
            end
            S_LOAD: begin
               r_state <= S_SHIFT;
               r_clr   <= 1'b0;
               r_en    <= 1'b1;
               r_din   <= r_sh[FW-1 -: P];
               r_sh    <= r_sh << P;
               r_cnt   <= '0;
            end
            S_SHIFT: begin
               if (r_cnt == CW'(NB - 1)) begin
                  r_state <= S_CAPT;
                  r_en    <= 1'b0;
                  r_din   <= '0;
               end else begin
                  r_cnt   <= r_cnt + CW'(1);
                  r_din   <= r_sh[FW-1 -: P];
                  r_sh    <= r_sh << P;
               end
            end
            S_CAPT: begin
               r_state <= S_DONE;
               r_res   <= crc_rem;
               r_vld   <= 1'b1;
            end
            S_DONE: begin
               if (res_ready) begin
                  r_state <= S_IDLE;
                  r_vld   <= 1'b0;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign crc_clr   = r_clr;
   assign crc_en    = r_en;
   assign crc_din   = r_din;
   assign res_valid = r_vld;
   assign res_data  = r_res;
   assign res_id    = r_id;
endmodule

// File: tb/tb_crc_frame_scheduler.sv
// Bench for crc_frame_scheduler: bit-serial CRC engine (g = x^9+x^4+1), long-division reference model, directed vectors.
module tb_crc_frame_scheduler;
   localparam int MSG_W = 10;
   localparam int CRC_W = 9;
   localparam int P     = 3;
   localparam int NB    = (MSG_W + CRC_W + P - 1) / P;
   localparam logic [9:0] GEN = 10'b10_0001_0001;

   logic             clk = 1'b0;
   logic             reset;
   logic             req0, req1;
   logic [MSG_W-1:0] msg0, msg1;
   logic             gnt0, gnt1;
   logic             crc_clr, crc_en;
   logic [P-1:0]     crc_din;
   logic [CRC_W-1:0] crc_rem;
   logic             res_valid, res_ready;
   logic [CRC_W-1:0] res_data;
   logic             res_id;

   int n_chk  = 0;
   int n_pass = 0;
   int tcyc   = 0;
   int gc, nbt, lat;
   logic [2:0] bts [8];

   crc_frame_scheduler #(.MSG_W(MSG_W), .CRC_W(CRC_W), .P(P)) dut (
      .clk(clk), .reset(reset),
      .req0(req0), .req1(req1), .msg0(msg0), .msg1(msg1),
      .gnt0(gnt0), .gnt1(gnt1),
      .crc_clr(crc_clr), .crc_en(crc_en), .crc_din(crc_din), .crc_rem(crc_rem),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_id(res_id)
   );

   always #5 clk = ~clk;
   always @(posedge clk) tcyc <= tcyc + 1;

   // Polynomial long division of msg * x^9 by the generator.
   function automatic logic [8:0] crc_ref(input logic [9:0] m);
      logic [18:0] v;
      v = {m, 9'b0};
      for (int i = 18; i >= 9; i--)
         if (v[i]) v = v ^ (19'(GEN) << (i - 9));
      return v[8:0];
   endfunction

   function automatic logic [2:0] beat_of(input logic [9:0] m, input int k);
      logic [20:0] f;
      f = 21'(m) << 9;
      return 3'((f >> (18 - 3 * k)) & 21'd7);
   endfunction

   function automatic logic [8:0] eng_step(input logic [8:0] r, input logic [2:0] d);
      logic [8:0] x;
      logic fb;
      x = r;
      for (int i = 2; i >= 0; i--) begin
         fb = x[8];
         x  = {x[7:0], d[i]};
         if (fb) x = x ^ 9'h011;
      end
      return x;
   endfunction

   logic [8:0] eng;
   always @(posedge clk or negedge reset) begin
      if (!reset)       eng <= '0;
      else if (crc_clr) eng <= '0;
      else if (crc_en)  eng <= eng_step(eng, crc_din);
   end
   assign crc_rem = eng;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
   endtask

   task automatic timeout_fail(input string nm);
      n_chk++;
      $display("FAIL %s: timed out waiting for DUT", nm);
   endtask

   task automatic wait_gnt(output int who);
      int n;
      n = 0;
      who = -1;
      while (n < 50 && who < 0) begin
         @(negedge clk);
         if (gnt0)      who = 0;
         else if (gnt1) who = 1;
         n++;
      end
      gc = tcyc;
      if (who < 0) timeout_fail("wait_gnt");
   endtask

   task automatic collect();
      int n;
      n = 0;
      nbt = 0;
      lat = -1;
      while (n < 40 && lat < 0) begin
         @(negedge clk);
         if (crc_en) begin
            if (nbt < 8) bts[nbt] = crc_din;
            nbt++;
         end
         if (res_valid) lat = tcyc - gc;
         n++;
      end
      if (lat < 0) timeout_fail("collect");
   endtask

   task automatic wait_valid();
      int n;
      n = 0;
      while (n < 40 && !res_valid) begin
         @(negedge clk);
         n++;
      end
      if (!res_valid) timeout_fail("wait_valid");
   endtask

   task automatic check_beats(input string nm, input logic [20:0] exp);
      check({nm, "_nbeats"}, 32'(nbt), 32'(NB));
      for (int k = 0; k < NB; k++)
         check($sformatf("%s_beat%0d", nm, k), 32'(bts[k]), 32'(exp[20 - 3 * k -: 3]));
   endtask

   // Cycle-by-cycle reference: phase relative to the grant cycle determines every output.
   initial begin : cmp
      int cyc, g, d;
      bit busy, ptr, mid, sel;
      bit e_g0, e_g1, e_clr, e_en, e_vld;
      logic [9:0] mmsg;
      cyc = 0; g = 0; busy = 0; ptr = 0; mid = 0; mmsg = '0; sel = 0;
      forever begin
         @(negedge clk);
         cyc++;
         if (!reset) begin
            busy = 0;
            ptr  = 0;
            check("rst_outputs", 32'({gnt0, gnt1, crc_clr, crc_en, crc_din, res_valid, res_id, res_data}), 32'd0);
         end else begin
            e_g0 = 0; e_g1 = 0; e_clr = 0; e_en = 0; e_vld = 0;
            if (!busy) begin
               if (req0 || req1) begin
`ifdef CRC_SCHED_RR_EN
                  sel = (req0 && req1) ? ptr : req1;
`else
                  sel = !req0;
`endif
                  e_g0 = !sel;
                  e_g1 = sel;
               end
            end else begin
               d     = cyc - g;
               e_clr = (d == 1);
               e_en  = (d >= 2 && d <= NB + 1);
               e_vld = (d >= NB + 3);
            end
            check("gnt0", 32'(gnt0), 32'(e_g0));
            check("gnt1", 32'(gnt1), 32'(e_g1));
            check("crc_clr", 32'(crc_clr), 32'(e_clr));
            check("crc_en", 32'(crc_en), 32'(e_en));
            check("res_valid", 32'(res_valid), 32'(e_vld));
            if (e_en) check("crc_din", 32'(crc_din), 32'(beat_of(mmsg, d - 2)));
            if (e_vld) begin
               check("res_data", 32'(res_data), 32'(crc_ref(mmsg)));
               check("res_id", 32'(res_id), 32'(mid));
            end
            if (!busy && (req0 || req1)) begin
               busy = 1;
               g    = cyc;
               mid  = sel;
               mmsg = sel ? msg1 : msg0;
               ptr  = !sel;
            end else if (busy && e_vld && res_ready) begin
               busy = 0;
            end
         end
      end
   end

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      int who, nv;
      int gs [3];
      int eg [3];
      logic [9:0] ma, mb;
      ma = 10'b1100000011;
      mb = 10'b1010110100;
`ifdef CRC_SCHED_RR_EN
      eg = '{0, 1, 0};
`else
      eg = '{0, 0, 0};
`endif
      reset = 1'b1; req0 = 0; req1 = 0; msg0 = '0; msg1 = '0; res_ready = 0;
      #1 reset = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_res_valid", 32'(res_valid), 32'd0);
      check("rst_crc_en", 32'(crc_en), 32'd0);
      @(posedge clk); #1 reset = 1'b1;

      // Basic operation, res_ready already high before res_valid.
      @(posedge clk); #1 res_ready = 1; msg0 = ma; req0 = 1;
      wait_gnt(who);
      check("t1_who", 32'(who), 32'd0);
      @(posedge clk); #1 req0 = 0;
      collect();
      check_beats("t1", 21'b001_100_000_011_000_000_000);
      check("t1_latency", 32'(lat), 32'd10);
      check("t1_res_data", 32'(res_data), 32'h0BA);
      check("t1_res_id", 32'(res_id), 32'd0);

      // Backpressure: result held while res_ready stays low.
      @(posedge clk); #1 res_ready = 0; msg1 = mb; req1 = 1;
      wait_gnt(who);
      check("t2_who", 32'(who), 32'd1);
      @(posedge clk); #1 req1 = 0;
      collect();
      check("t2_latency", 32'(lat), 32'd10);
      for (int i = 0; i < 5; i++) begin
         if (i > 0) @(negedge clk);
         check("t2_hold_valid", 32'(res_valid), 32'd1);
         check("t2_hold_data", 32'(res_data), 32'h0A0);
         check("t2_hold_id", 32'(res_id), 32'd1);
      end
      @(posedge clk); #1 res_ready = 1;
      @(negedge clk);
      check("t2_ready_cycle_valid", 32'(res_valid), 32'd1);
      @(posedge clk); #1 res_ready = 0;
      @(negedge clk);
      check("t2_idle_valid", 32'(res_valid), 32'd0);

      // Contention over three back-to-back operations.
      @(posedge clk); #1 res_ready = 1; msg0 = ma; msg1 = mb; req0 = 1; req1 = 1;
      for (int k = 0; k < 3; k++) begin
         wait_gnt(who);
         gs[k] = who;
      end
      @(posedge clk); #1 req0 = 0; req1 = 0;
      wait_valid();
      for (int k = 0; k < 3; k++) check($sformatf("t3_grant%0d", k), 32'(gs[k]), 32'(eg[k]));

      // Reset in the 4th SHIFT cycle aborts the operation.
      @(posedge clk); #1 msg0 = ma; req0 = 1;
      wait_gnt(who);
      @(posedge clk); #1 req0 = 0;
      repeat (4) @(posedge clk);
      #1 reset = 1'b0;
      #1 check("t4_abort_crc_en", 32'(crc_en), 32'd0);
      check("t4_abort_valid", 32'(res_valid), 32'd0);
      @(posedge clk); @(posedge clk); #1 reset = 1'b1;
      nv = 0;
      repeat (15) begin
         @(negedge clk);
         if (res_valid) nv++;
      end
      check("t4_no_valid_after_abort", 32'(nv), 32'd0);
      @(posedge clk); #1 msg0 = ma; req0 = 1;
      wait_gnt(who);
      check("t4_who", 32'(who), 32'd0);
      @(posedge clk); #1 req0 = 0;
      collect();
      check_beats("t4", 21'b001_100_000_011_000_000_000);
      check("t4_latency", 32'(lat), 32'd10);
      check("t4_res_data", 32'(res_data), 32'h0BA);

      // Request dropped and message changed right after the grant.
      @(posedge clk); #1 msg0 = mb; req0 = 1;
      wait_gnt(who);
      check("t5_who", 32'(who), 32'd0);
      @(posedge clk); #1 req0 = 0; msg0 = 10'b0101010101;
      collect();
      check_beats("t5", 21'b001_010_110_100_000_000_000);
      check("t5_res_data", 32'(res_data), 32'h0A0);
      check("t5_res_id", 32'(res_id), 32'd0);

      repeat (3) @(posedge clk);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
